uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
Downstream stage of the message printer. Accepts one byte per handshake (tx_data/new_tx_data, back-pressure via tx_busy) and serialises it onto the UART TX line as start bit, 8 data bits LSB first, optional parity bit, and 1 or 2 stop bits. Sits between the printer and the TX pin. Also offers a flow-control hold-off input.

Parameters:
CLK_PER_BIT, 50, clocks per serial bit (50 MHz / 1 Mbaud); legal range 2..65535
STOP_BITS, 1, number of stop bits; legal values 1 or 2
PARITY_EN, 0, 1 = insert a parity bit after data bit 7
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
block  in  1  hold-off; while high no new frame is accepted
data  in  8  byte to send; connects to printer tx_data
new_data  in  1  byte-valid strobe; connects to printer new_tx_data
busy  out  1  registered; high = new_data ignored; connects to printer tx_busy
tx  out  1  serial line, idle high

Behaviour:
- Reset: asynchronous; state=IDLE, tx=1, busy=1 while rst is high, busy=0 first cycle after release (if block low), counters=0, shift register=0.
- tx and busy are registered outputs; no combinational path from any input to any output.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. busy = block, registered one cycle. Accept when state=IDLE && !busy && new_data: latch data into shift register; go to START next cycle; busy=1 next cycle.
- new_data while busy=1 is dropped silently; no queuing.
- START: tx=0 for CLK_PER_BIT cycles, then DATA.
- DATA: tx=shift[0] for CLK_PER_BIT cycles per bit; shift right after each bit. Bit counter runs 0..7. After bit 7 go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = XOR of the 8 latched bits, XOR PARITY_ODD; held CLK_PER_BIT cycles; then STOP.
- STOP: tx=1 for STOP_BITS*CLK_PER_BIT cycles; then IDLE.
- Frame length: CLK_PER_BIT*(10+PARITY_EN+STOP_BITS-1) cycles, measured from the first START cycle to the last STOP cycle inclusive.
- Back-to-back frames: busy falls the first IDLE cycle after STOP. An accept is possible in that same cycle. START begins the following cycle. Minimum inter-frame gap is therefore 1 clock of tx=1 beyond the stop bits.
- block rising mid-frame: the current frame completes unaltered; busy stays high after return to IDLE until block falls.
- block and new_data high in the same IDLE cycle with busy=0: the byte is accepted (busy was already low). block takes effect the next cycle.
- Bit-time counter: width clog2(CLK_PER_BIT); resets to 0 on every bit boundary; wrap at CLK_PER_BIT-1.
- Reset mid-frame: tx returns to 1 immediately (asynchronously); the partial frame is abandoned; no resumption.
- Any illegal state encoding returns to IDLE with tx=1.

Decomposition:
- Shared package uart_pkg holds the state enum (IDLE, START, DATA, PARITY, STOP), the DATA_BITS=8 constant, and a clog2-based counter-width function. The uart_rx side reuses it.
- One sub-module: uart_bit_timer.
  - Parameter CLK_PER_BIT.
  - Inputs: clk, rst, restart.
  - Output: bit_done, a one-cycle pulse every CLK_PER_BIT cycles.
  - The FSM, shift register and parity generation stay in uart_tx_framer.

Test Plan:
- Basic frame: CLK_PER_BIT=4, defaults, send data=0x68 with new_data one cycle → busy=1 next cycle. tx over 40 cycles is 0,0,0,0,1,0,1,1,0,1 per 4-cycle bit (start, LSB-first data, stop). busy=0 on cycle 41.
- Even parity: PARITY_EN=1, PARITY_ODD=0, send 0x68 → parity bit=1 (three ones), frame 44 cycles. Repeat with PARITY_ODD=1 → parity bit=0.
- Back-to-back: printer-style source holds new_data high whenever busy=0, sends 0x41 then 0x42 → exactly two frames; exactly 1 idle-high clock between the stop bit of 0x41 and the start bit of 0x42. No byte is duplicated or dropped.
- Drop while busy: pulse new_data with 0x55 mid-frame of 0x68 → only 0x68 appears on tx; busy never falls early.
- Block: raise block during the data bits of 0x68 → frame completes intact. busy stays 1 while block is high and new_data is ignored. Release block → busy=0 next cycle; the next byte sends normally.
- Reset mid-frame: assert rst asynchronously during data bit 3 → tx=1 and busy=1 before the next clk edge. After release, state is IDLE and the next 0xA5 frame is correct; STOP_BITS=2 variant gives 8 stop cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width, counter sizing.
// Used by both the TX framer and the RX side.
// Pure declarations, no logic.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int DATA_BITS = 8;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: bit_done pulses for one cycle every CLK_PER_BIT cycles.
// Latency: first pulse CLK_PER_BIT cycles after restart drops.
// No backpressure; restart holds the count at zero.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int W = cnt_width(CLK_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLK_PER_BIT - 1);

  logic [W-1:0] cnt;

  // Count the cycles of one bit, wrapping to zero on every bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign bit_done = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: serialises one byte per accept as start, 8 data LSB first, optional parity, stop bit(s).
// Latency: START begins the cycle after accept; frame lasts CLK_PER_BIT*(10+PARITY_EN+STOP_BITS-1) cycles.
// Backpressure: busy (registered) high during a frame or while block is high; new_data while busy is dropped.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 50,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       block,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       busy,
  output logic       tx
);

  uart_state_t          state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_cnt;
  logic                 par;
  logic                 restart;
  logic                 bit_done;

  // The bit timer idles at zero so the first START cycle begins a fresh bit period.
  assign restart = (state == IDLE);

  uart_bit_timer #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .bit_done (bit_done)
  );

  // Frame FSM; tx and busy are loaded with the value for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b1;
      shift   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          bit_cnt <= '0;
          if (!busy && new_data) begin
            // Parity is taken from the byte as latched, before any shifting.
            shift <= data;
            par   <= (^data) ^ 1'(PARITY_ODD);
            busy  <= 1'b1;
            tx    <= 1'b0;
            state <= START;
          end else begin
            busy <= block;
          end
        end
        START: begin
          if (bit_done) begin
            tx    <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            shift <= {1'b0, shift[DATA_BITS-1:1]};
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (bit_cnt == 3'(STOP_BITS - 1)) begin
              // busy drops in the first IDLE cycle unless the hold-off is asserted.
              bit_cnt <= '0;
              busy    <= block;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          busy    <= 1'b1;
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench: three framer configurations share stimulus; per-DUT monitors check every cycle
// of each frame against a scoreboard of expected bytes.
// Configurations: 0 = 8N1, 1 = even parity + 2 stop, 2 = odd parity + 1 stop; all at 4 clocks per bit.
module tb_uart_tx_framer;

  typedef struct {
    logic [7:0] data;
    logic       par_even;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       block = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] nd = 3'b000;
  logic       busy0, busy1, busy2, tx0, tx1, tx2;
  logic [2:0] busy_v, tx_v;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int frames[3] = '{0, 0, 0};
  int start_cyc[3] = '{0, 0, 0};
  int gap[3] = '{0, 0, 0};

  int cfg_par[3]  = '{0, 1, 1};
  int cfg_odd[3]  = '{0, 0, 1};
  int cfg_stop[3] = '{1, 2, 1};
  int flen[3]     = '{40, 48, 44};

  item_t q0[$], q1[$], q2[$];

  assign busy_v = {busy2, busy1, busy0};
  assign tx_v   = {tx2, tx1, tx0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_framer #(.CLK_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .block(block), .data(data), .new_data(nd[0]), .busy(busy0), .tx(tx0));
  uart_tx_framer #(.CLK_PER_BIT(4), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst), .block(block), .data(data), .new_data(nd[1]), .busy(busy1), .tx(tx1));
  uart_tx_framer #(.CLK_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
    .clk(clk), .rst(rst), .block(block), .data(data), .new_data(nd[2]), .busy(busy2), .tx(tx2));

  task automatic push(input int idx, input item_t it);
    case (idx)
      0: q0.push_back(it);
      1: q1.push_back(it);
      default: q2.push_back(it);
    endcase
  endtask

  function automatic int qsize(input int idx);
    case (idx)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic item_t qpop(input int idx);
    case (idx)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Decode each frame on one DUT's tx line and compare every cycle, plus the idle cycle after it.
  task automatic mon(input int idx);
    item_t       it;
    logic [12:0] expw, gotw;
    int          nb, bad, t0;
    bit          abort;
    forever begin
      @(negedge clk);
      if (!rst && tx_v[idx] === 1'b0) begin
        t0 = cyc;
        nb = 9 + cfg_par[idx] + cfg_stop[idx];
        if (qsize(idx) == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame dut%0d: start bit at cycle %0d, required no frame", idx, t0);
          repeat (nb * 4) @(negedge clk);
        end else begin
          it = qpop(idx);
          expw = '1;
          expw[0] = 1'b0;
          for (int i = 0; i < 8; i++) expw[1+i] = it.data[i];
          if (cfg_par[idx] != 0) expw[9] = it.par_even ^ 1'(cfg_odd[idx]);
          gotw = '1;
          bad = 0;
          abort = 0;
          for (int c = 0; c < nb * 4 + 1; c++) begin
            if (c > 0) @(negedge clk);
            if (rst) begin
              abort = 1;
              break;
            end
            if (c == nb * 4) begin
              if (tx_v[idx] !== 1'b1) bad++;
            end else begin
              if (tx_v[idx] !== expw[c/4]) bad++;
              if (c % 4 == 2) gotw[c/4] = tx_v[idx];
            end
          end
          if (abort) begin
            while (rst || tx_v[idx] !== 1'b1) @(negedge clk);
          end else begin
            vectors++;
            if (bad != 0) begin
              miscompares++;
              $display("FAIL frame dut%0d byte %h: bits got %b, required %b (%0d bad cycles)",
                       idx, it.data, gotw, expw, bad);
            end
            gap[idx] = t0 - start_cyc[idx];
            start_cyc[idx] = t0;
            frames[idx]++;
          end
        end
      end
    end
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
    join
  end

  task automatic wait_idle_all();
    int n = 0;
    while (busy_v !== 3'b000 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(busy_v), 32'd0);
  endtask

  // Called at a negedge with all DUTs idle; returns at the negedge of the first START cycle.
  task automatic send_all(input logic [7:0] d, input logic pe);
    item_t it;
    it.data = d;
    it.par_even = pe;
    data = d;
    nd = 3'b111;
    for (int i = 0; i < 3; i++) push(i, it);
    @(negedge clk);
    nd = 3'b000;
  endtask

  // One frame on all DUTs; optional drop pulse or block assertion at a given cycle into the frame.
  task automatic run_frame(input logic [7:0] d, input logic pe, input int drop_at, input int block_at);
    int fall[3];
    wait_idle_all();
    send_all(d, pe);
    fall = '{0, 0, 0};
    for (int c = 1; c <= 80; c++) begin
      for (int i = 0; i < 3; i++)
        if (fall[i] == 0 && busy_v[i] === 1'b0) fall[i] = c;
      nd   = (c == drop_at) ? 3'b111 : 3'b000;
      data = (c == drop_at) ? 8'h55 : d;
      if (c == block_at) block = 1'b1;
      @(negedge clk);
    end
    nd = 3'b000;
    data = d;
    if (block_at == 0) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("busy_fall_cycle_dut%0d_%h", i, d), 32'(fall[i]), 32'(flen[i] + 1));
    end else begin
      for (int i = 0; i < 3; i++)
        check($sformatf("busy_held_by_block_dut%0d", i), 32'(fall[i]), 32'd0);
      nd = 3'b111;
      data = 8'h55;
      @(negedge clk);
      nd = 3'b000;
      data = d;
      repeat (3) @(negedge clk);
      check("busy_blocked_after_pulse", 32'(busy_v), 32'h7);
      block = 1'b0;
      @(negedge clk);
      check("busy_after_unblock", 32'(busy_v), 32'd0);
    end
  endtask

  initial begin
    item_t tbl[8];
    item_t it;
    int    f0, sent, n;
    bit    acc;

    tbl[0] = '{8'h68, 1'b1};
    tbl[1] = '{8'h00, 1'b0};
    tbl[2] = '{8'hFF, 1'b0};
    tbl[3] = '{8'h01, 1'b1};
    tbl[4] = '{8'hA5, 1'b0};
    tbl[5] = '{8'h80, 1'b1};
    tbl[6] = '{8'h7E, 1'b0};
    tbl[7] = '{8'h37, 1'b1};

    // Reset state and release.
    @(negedge clk);
    check("reset_tx", 32'(tx_v), 32'h7);
    check("reset_busy", 32'(busy_v), 32'h7);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 32'(busy_v), 32'd0);
    check("post_reset_tx", 32'(tx_v), 32'h7);

    // Table of bytes, each checked on all three configurations.
    for (int i = 0; i < 8; i++) run_frame(tbl[i].data, tbl[i].par_even, 0, 0);

    // new_data pulsed mid-frame must be dropped.
    run_frame(8'h68, 1'b1, 10, 0);

    // block raised during the data bits.
    run_frame(8'h68, 1'b1, 0, 20);

    // Back-to-back on configuration 0 with a source that holds new_data while busy is low.
    wait_idle_all();
    f0 = frames[0];
    it = '{8'h41, 1'b0};
    push(0, it);
    data = 8'h41;
    nd[0] = 1'b1;
    sent = 0;
    for (int c = 0; c < 200 && sent < 2; c++) begin
      acc = (busy_v[0] === 1'b0);
      @(negedge clk);
      if (acc) begin
        sent++;
        if (sent == 1) begin
          it = '{8'h42, 1'b0};
          push(0, it);
          data = 8'h42;
        end else begin
          nd[0] = 1'b0;
        end
      end
    end
    nd[0] = 1'b0;
    check("b2b_accepts", 32'(sent), 32'd2);
    n = 0;
    while (frames[0] < f0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_start_spacing", 32'(gap[0]), 32'd41);
    repeat (60) @(negedge clk);
    check("b2b_frame_count", 32'(frames[0] - f0), 32'd2);

    // Asynchronous reset during data bit 3 of 0x00.
    wait_idle_all();
    send_all(8'h00, 1'b0);
    repeat (17) @(negedge clk);
    check("pre_reset_tx_low", 32'(tx_v), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_tx", 32'(tx_v), 32'h7);
    check("async_reset_busy", 32'(busy_v), 32'h7);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("busy_after_midframe_reset", 32'(busy_v), 32'd0);
    check("tx_after_midframe_reset", 32'(tx_v), 32'h7);
    run_frame(8'hA5, 1'b0, 0, 0);

    // Drain and account for every expected frame.
    wait_idle_all();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("queue_empty_dut%0d", i), 32'(qsize(i)), 32'd0);
    check("frames_dut0", 32'(frames[0]), 32'd13);
    check("frames_dut1", 32'(frames[1]), 32'd11);
    check("frames_dut2", 32'(frames[2]), 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
